// File: rtl/seq_multiplier_pkg.sv
// Shared constants for the sequential shift-add multiplier: FSM encoding,
// default operand width and the iteration counter sizing helper.
package seq_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CALC = 1'b1;

  // Counter must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    int cw;
    cw = $clog2(w);
    if (cw < 1) begin
      cw = 1;
    end else begin
      cw = cw;
    end
    return cw;
  endfunction

endpackage

// File: rtl/seq_multiplier_cond_negate.sv
// Combinational conditional two's-complement: OUT = NEG ? -IN : IN.
module cond_negate #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] IN,
  input  logic             NEG,
  output logic [WIDTH-1:0] OUT
);

  // Invert-and-increment when NEG is set, pass through otherwise.
  always_comb begin
    if (NEG) begin
      OUT = ~IN + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      OUT = IN;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: WIDTH-cycle iteration on operand magnitudes,
// sign applied to the double-width product on the final edge.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               SIGNED_MODE,
  input  logic [WIDTH-1:0]   DATA1,
  input  logic [WIDTH-1:0]   DATA2,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0]   RESULT_LO
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [0:0]         state_q,  state_d;
  logic [CW-1:0]      count_q,  count_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               neg_q,    neg_d;
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q,    acc_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               neg1_s;
  logic               neg2_s;
  logic [WIDTH-1:0]   mag1_s;
  logic [WIDTH-1:0]   mag2_s;
  logic [WIDTH:0]     addend_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] product_s;
  logic [2*WIDTH-1:0] signed_prod_s;

  assign neg1_s = SIGNED_MODE & DATA1[WIDTH-1];
  assign neg2_s = SIGNED_MODE & DATA2[WIDTH-1];

  // Magnitude of the most-negative value still fits as an unsigned WIDTH-bit number.
  cond_negate #(.WIDTH(WIDTH)) u_mag1 (
    .IN  (DATA1),
    .NEG (neg1_s),
    .OUT (mag1_s)
  );

  cond_negate #(.WIDTH(WIDTH)) u_mag2 (
    .IN  (DATA2),
    .NEG (neg2_s),
    .OUT (mag2_s)
  );

  // WIDTH+1-bit add keeps the carry that is shifted back into the accumulator MSB.
  assign addend_s  = mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}};
  assign sum_s     = {1'b0, acc_q} + addend_s;
  assign product_s = {sum_s[WIDTH:1], sum_s[0], mplier_q[WIDTH-1:1]};

  cond_negate #(.WIDTH(2*WIDTH)) u_prod_neg (
    .IN  (product_s),
    .NEG (neg_q),
    .OUT (signed_prod_s)
  );

  // Control next-state: IDLE/CALC sequencing, iteration count and status flags.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_CALC;
          count_d = {CW{1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (count_q == LAST) begin
          state_d = ST_IDLE;
          count_d = {CW{1'b0}};
          done_d  = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = {CW{1'b0}};
      end
    endcase
  end

  // Datapath next-state: operand latch, shift-add step and product capture.
  always_comb begin
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          mcand_d  = mag1_s;
          mplier_d = mag2_s;
          acc_d    = {WIDTH{1'b0}};
          neg_d    = SIGNED_MODE & (DATA1[WIDTH-1] ^ DATA2[WIDTH-1]);
        end else begin
          acc_d = acc_q;
        end
      end
      ST_CALC: begin
        acc_d    = sum_s[WIDTH:1];
        mplier_d = {sum_s[0], mplier_q[WIDTH-1:1]};
        if (count_q == LAST) begin
          result_d = signed_prod_s;
        end else begin
          result_d = result_q;
        end
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  // State, counter and status registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      count_q <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      neg_q    <= 1'b0;
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      result_q <= {(2*WIDTH){1'b0}};
    end else begin
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign RESULT    = result_q;
  assign RESULT_LO = result_q[WIDTH-1:0];

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: WIDTH=8 and WIDTH=16 instances, directed vectors.
module tb_seq_multiplier;
  import seq_multiplier_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] res8;
  logic [7:0]  lo8;
  logic        s16, sm16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [31:0] res16;
  logic [15:0] lo16;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q8[$];
  exp_t q16[$];

  seq_multiplier #(.WIDTH(DEFAULT_WIDTH)) dut8 (
    .CLK(clk), .RESET(rst), .START(s8), .SIGNED_MODE(sm8), .DATA1(a8), .DATA2(b8),
    .BUSY(busy8), .DONE(done8), .RESULT(res8), .RESULT_LO(lo8)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .CLK(clk), .RESET(rst), .START(s16), .SIGNED_MODE(sm16), .DATA1(a16), .DATA2(b16),
    .BUSY(busy16), .DONE(done16), .RESULT(res16), .RESULT_LO(lo16)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitors: pop the oldest expectation whenever DONE is presented.
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      check("busy_done_excl8", {31'b0, busy8}, 32'd0);
      if (q8.size() == 0) begin
        errors++; checks++;
        $display("FAIL spurious_done8: got DONE=1 required no pending op (cycle %0d)", cyc);
      end else begin
        e = q8.pop_front();
        check("result8", {16'h0, res8}, e.res);
        check("result_lo8", {24'h0, lo8}, {24'h0, e.res[7:0]});
        check("latency8", cyc, e.due);
      end
    end
    if (done16) begin
      check("busy_done_excl16", {31'b0, busy16}, 32'd0);
      if (q16.size() == 0) begin
        errors++; checks++;
        $display("FAIL spurious_done16: got DONE=1 required no pending op (cycle %0d)", cyc);
      end else begin
        e = q16.pop_front();
        check("result16", res16, e.res);
        check("result_lo16", {16'h0, lo16}, {16'h0, e.res[15:0]});
        check("latency16", cyc, e.due);
      end
    end
  end

  // One-cycle START for the 8-bit instance; expectation due 8 edges after acceptance.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input logic [15:0] exp);
    @(negedge clk);
    s8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
    q8.push_back('{res: {16'h0, exp}, due: cyc + 1 + 8});
    @(negedge clk);
    s8 = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                         input logic [31:0] exp);
    @(negedge clk);
    s16 = 1'b1; a16 = a; b16 = b; sm16 = sm;
    q16.push_back('{res: exp, due: cyc + 1 + 16});
    @(negedge clk);
    s16 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0 || q16.size() != 0) begin
      errors++; checks++;
      $display("FAIL drain_timeout: got %0d/%0d pending required 0", q8.size(), q16.size());
      q8.delete();
      q16.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    s8 = 1'b0; sm8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    s16 = 1'b0; sm16 = 1'b0; a16 = 16'd0; b16 = 16'd0;
    repeat (3) @(negedge clk);
    check("reset_busy8", {31'b0, busy8}, 32'd0);
    check("reset_done8", {31'b0, done8}, 32'd0);
    check("reset_result8", {16'h0, res8}, 32'd0);
    check("reset_result16", res16, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Unsigned WIDTH=8
    issue8(8'd3,   8'd5,   1'b0, 16'd15);   drain();
    issue8(8'd10,  8'd5,   1'b0, 16'd50);   drain();
    issue8(8'd8,   8'd5,   1'b0, 16'd40);   drain();
    issue8(8'd5,   8'd5,   1'b0, 16'd25);   drain();
    issue8(8'd255, 8'd255, 1'b0, 16'hFE01); drain();
    issue8(8'd0,   8'd200, 1'b0, 16'd0);    drain();

    // Signed WIDTH=8
    issue8(8'hFD, 8'h05, 1'b1, 16'hFFF1); drain();
    issue8(8'h80, 8'h80, 1'b1, 16'h4000); drain();
    issue8(8'h80, 8'h01, 1'b1, 16'hFF80); drain();
    issue8(8'h7F, 8'hFF, 1'b1, 16'hFF81); drain();

    // START held for 27 cycles: accepted at offsets 0, 9, 18
    @(negedge clk);
    s8 = 1'b1; a8 = 8'd12; b8 = 8'd11; sm8 = 1'b0;
    for (int j = 0; j < 3; j++) q8.push_back('{res: 32'd132, due: cyc + 1 + j * 9 + 8});
    repeat (27) @(negedge clk);
    s8 = 1'b0;
    drain();

    // START pulses during BUSY (including the final CALC edge) are ignored
    issue8(8'd9, 8'd9, 1'b0, 16'd81);
    repeat (2) @(negedge clk);
    s8 = 1'b1; a8 = 8'd2; b8 = 8'd2;
    @(negedge clk);
    s8 = 1'b0;
    repeat (4) @(negedge clk);
    s8 = 1'b1; a8 = 8'd3; b8 = 8'd3;
    @(negedge clk);
    s8 = 1'b0;
    drain();

    // Operand and mode changes after the latch edge have no effect
    issue8(8'd7, 8'd6, 1'b0, 16'd42);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h80; sm8 = 1'b1;
    drain();

    // RESET in the middle of CALC aborts without DONE
    @(negedge clk);
    s8 = 1'b1; a8 = 8'd100; b8 = 8'd100; sm8 = 1'b0;
    @(negedge clk);
    s8 = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_abort", {31'b0, busy8}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, busy8}, 32'd0);
    check("abort_done", {31'b0, done8}, 32'd0);
    check("abort_result", {16'h0, res8}, 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_result_held", {16'h0, res8}, 32'd0);
    issue8(8'd6, 8'd7, 1'b0, 16'd42); drain();

    // WIDTH=16 instance
    issue16(16'd1000, 16'd3000, 1'b0, 32'd3000000); drain();
    issue16(16'hFFFF, 16'hFFFF, 1'b1, 32'd1);       drain();
    issue16(16'h8000, 16'h0002, 1'b1, 32'hFFFF0000); drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
